// File: rtl/disp_mux_scheduler.sv
// disp_mux_scheduler: time-multiplexes four hex digits onto one active-low 7-seg + DP bus,
// with per-slot blanking dead-time and a once-per-frame input snapshot.
module disp_mux_scheduler #(
    parameter int N            = 18,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hex0,
    input  logic [3:0] hex1,
    input  logic [3:0] hex2,
    input  logic [3:0] hex3,
    input  logic [3:0] dp_in,
    input  logic [3:0] en,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_start
);
    localparam logic [N-3:0] BLANK = BLANK_CYCLES[N-3:0];
    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [N-1:0] q;
    logic [15:0]  shadow_hex;
    logic [3:0]   shadow_dp;
    logic [3:0]   shadow_en;
    logic [1:0]   d;
    logic [N-3:0] o;
    logic [3:0]   cur_hex;
    logic         show;
    assign d       = q[N-1:N-2];
    assign o       = q[N-3:0];
    assign cur_hex = shadow_hex[{d, 2'b00} +: 4];
    // Dead-time at slot start also hides the stale shadow while q==0 reloads it.
    assign show    = (o >= BLANK) && shadow_en[d];
    always_ff @(posedge clk) begin
        if (reset) begin
            q           <= '0;
            shadow_hex  <= '0;
            shadow_dp   <= '0;
            shadow_en   <= '0;
            an          <= 4'b1111;
            sseg        <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            q           <= q + 1'b1;
            an          <= show ? ~(4'b0001 << d) : 4'b1111;
            sseg        <= show ? {~shadow_dp[d], SEG[cur_hex]} : 8'hFF;
            frame_start <= (q == '0);
            if (q == '0) begin
                shadow_hex <= {hex3, hex2, hex1, hex0};
                shadow_dp  <= dp_in;
                shadow_en  <= en;
            end
        end
    end
endmodule

// File: tb/tb_disp_mux_scheduler.sv
// tb_disp_mux_scheduler: scoreboard bench; a frame-position reference model predicts
// every output edge and an independent monitor compares the registered outputs.
module tb_disp_mux_scheduler;
    localparam int N     = 6;
    localparam int BL    = 2;
    localparam int FRAME = 64;
    localparam int S     = 16;
    localparam logic [6:0] SEG_T [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef struct packed {
        logic [3:0] an;
        logic [7:0] sseg;
        logic       fs;
    } exp_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] h [4];
    logic [3:0] dp_in, en;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame_start;
    int         tests = 0;
    int         fails = 0;
    exp_t       sbq [$];
    int         mp = 0;
    logic [3:0] sh_h [4];
    logic [3:0] sh_dp, sh_en;

    always #5 clk = ~clk;

    disp_mux_scheduler #(.N(N), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .reset(reset),
        .hex0(h[0]), .hex1(h[1]), .hex2(h[2]), .hex3(h[3]),
        .dp_in(dp_in), .en(en),
        .an(an), .sseg(sseg), .frame_start(frame_start)
    );

    // Reference: mp is the position in the frame of the upcoming edge.
    task automatic step();
        exp_t e;
        int slot, off;
        e.an = 4'b1111;
        e.sseg = 8'hFF;
        e.fs = 1'b0;
        if (reset) begin
            mp = 0;
            sh_h = '{4'd0, 4'd0, 4'd0, 4'd0};
            sh_dp = 4'd0;
            sh_en = 4'd0;
        end else begin
            slot = mp / S;
            off  = mp % S;
            e.fs = (mp == 0);
            if (off >= BL && sh_en[slot]) begin
                e.an = 4'b1111;
                e.an[slot] = 1'b0;
                e.sseg = {~sh_dp[slot], SEG_T[sh_h[slot]]};
            end
            if (mp == 0) begin
                sh_h = h;
                sh_dp = dp_in;
                sh_en = en;
            end
            mp = (mp + 1) % FRAME;
        end
        sbq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 4; i++) h[i] = 4'($urandom_range(0, 15));
        dp_in = 4'($urandom_range(0, 15));
        en    = 4'($urandom_range(0, 15));
    endtask

    always @(posedge clk) begin
        #1;
        tests++;
        if (sbq.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            exp_t e;
            e = sbq.pop_front();
            if ({an, sseg, frame_start} !== e) begin
                fails++;
                $display("FAIL outputs at %0t: an=%b sseg=%h fs=%b, expected an=%b sseg=%h fs=%b",
                         $time, an, sseg, frame_start, e.an, e.sseg, e.fs);
            end
        end
        tests++;
        if ($countones(~an) > 1) begin
            fails++;
            $display("FAIL an_onehot at %0t: an=%b, expected at most one low bit", $time, an);
        end
    end

    initial begin
        h = '{4'd0, 4'd0, 4'd0, 4'd0};
        dp_in = 4'd0;
        en = 4'd0;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (37) step();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        h = '{4'd0, 4'd1, 4'd2, 4'd3};
        en = 4'hF;
        dp_in = 4'd0;
        repeat (FRAME) step();
        repeat (20) step();
        h[0] = 4'hF;
        repeat (FRAME - 20) step();
        repeat (FRAME) step();
        en = 4'b1010;
        dp_in = 4'b0010;
        repeat (FRAME) step();
        for (int i = 0; i < 6 * FRAME; i++) begin
            if ($urandom_range(0, 15) == 0) rand_inputs();
            step();
        end
        repeat ($urandom_range(1, 50)) step();
        reset = 1'b1;
        repeat ($urandom_range(1, 4)) step();
        reset = 1'b0;
        en = 4'hF;
        for (int v = 0; v < 16; v++) begin
            h[0] = 4'(v);
            dp_in = 4'($urandom_range(0, 15));
            repeat (FRAME) step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
